// File: rtl/apb_pkg.sv
// apb_pkg: shared types and constants for the APB master.
//   apb_state_e : 2-bit FSM state encoding (IDLE=00, SETUP=01, ACCESS=10)
//   TO_CNT_W    : width of the ACCESS timeout down-counter; TIMEOUT_CYC
//                 must not exceed 2**TO_CNT_W
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SETUP  = 2'b01,
    ACCESS = 2'b10
  } apb_state_e;

  localparam int TO_CNT_W = 16;

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: ACCESS-phase watchdog, down-counter with terminal-count
// compare. Only present in builds with APB_MASTER_TIMEOUT_EN defined.
// Ports:
//   P_clk, P_rst : clock, async active-high reset
//   load         : reload to TIMEOUT_CYC-1 (asserted during SETUP)
//   en           : count enable (asserted during ACCESS)
//   expired      : high in the ACCESS cycle that is the TIMEOUT_CYC-th one
module apb_timeout_cnt
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic P_clk,
  input  logic P_rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [TO_CNT_W-1:0] LOAD_VAL = TO_CNT_W'(TIMEOUT_CYC - 1);

  logic [TO_CNT_W-1:0] cnt;

  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Loaded with N-1, so the zero compare lands on the N-th ACCESS cycle.
  assign expired = en && (cnt == '0);

endmodule

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester. Takes a command on a
// valid/ready handshake, runs one SETUP/ACCESS transfer, and returns a
// one-cycle response pulse (no backpressure).
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort ACCESS phases
// that see no P_ready for TIMEOUT_CYC cycles (rsp_err=1, rsp_rdata=0).
// Ports:
//   P_clk, P_rst                         : clock, async active-high reset
//   cmd_valid/cmd_ready                  : command handshake
//   cmd_write, cmd_addr, cmd_wdata       : command payload
//   rsp_valid, rsp_rdata, rsp_err        : response pulse
//   P_addr, P_selx, P_enable, P_write,
//   P_wdata                              : APB request outputs
//   P_ready, P_slverr, P_rdata           : APB completion inputs
//
// state  | meaning
// IDLE   | no transfer; cmd_ready=1; APB payload holds last values
// SETUP  | P_selx=1, P_enable=0 for exactly one cycle
// ACCESS | P_selx=1, P_enable=1 until P_ready (or timeout)
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              P_clk,
  input  logic              P_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] P_addr,
  output logic              P_selx,
  output logic              P_enable,
  output logic              P_write,
  output logic [DATA_W-1:0] P_wdata,
  input  logic              P_ready,
  input  logic              P_slverr,
  input  logic [DATA_W-1:0] P_rdata
);

  apb_state_e state;
  logic       timeout_hit;

`ifdef APB_MASTER_TIMEOUT_EN
  apb_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout_cnt (
    .P_clk  (P_clk),
    .P_rst  (P_rst),
    .load   (state == SETUP),
    .en     (state == ACCESS),
    .expired(timeout_hit)
  );
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  // Gated by P_rst so ready is low while held in reset, yet high in the
  // very first cycle after release.
  assign cmd_ready = (state == IDLE) && !P_rst;

  always_ff @(posedge P_clk or posedge P_rst) begin
    if (P_rst) begin
      state     <= IDLE;
      P_selx    <= 1'b0;
      P_enable  <= 1'b0;
      P_write   <= 1'b0;
      P_addr    <= '0;
      P_wdata   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            P_write <= cmd_write;
            P_addr  <= cmd_addr;
            P_wdata <= cmd_wdata;
            P_selx  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          P_enable <= 1'b1;
          state    <= ACCESS;
        end
        ACCESS: begin
          // A real P_ready wins over a timeout landing in the same cycle.
          if (P_ready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= P_write ? '0 : P_rdata;
            rsp_err   <= P_slverr;
            P_selx    <= 1'b0;
            P_enable  <= 1'b0;
            state     <= IDLE;
          end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            P_selx    <= 1'b0;
            P_enable  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          P_selx   <= 1'b0;
          P_enable <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              P_clk = 1'b0;
  logic              P_rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] P_addr;
  logic              P_selx;
  logic              P_enable;
  logic              P_write;
  logic [DATA_W-1:0] P_wdata;
  logic              P_ready = 1'b0;
  logic              P_slverr = 1'b0;
  logic [DATA_W-1:0] P_rdata = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(16)) dut (
    .P_clk(P_clk), .P_rst(P_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .P_addr(P_addr), .P_selx(P_selx), .P_enable(P_enable),
    .P_write(P_write), .P_wdata(P_wdata),
    .P_ready(P_ready), .P_slverr(P_slverr), .P_rdata(P_rdata)
  );

  always #5 P_clk = ~P_clk;
  always @(posedge P_clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    int                waits;
    logic              slverr;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs[6];

  // Must be entered at a negedge. Runs one full transfer and checks every phase.
  task automatic run_vec(input vec_t v);
    int acc;
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr; cmd_wdata = v.wdata;
    #1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(negedge P_clk);
    cmd_valid = 1'b0;
    chk("setup_selx", P_selx, 1);
    chk("setup_enable", P_enable, 0);
    chk("setup_addr", P_addr, v.addr);
    chk("setup_write", P_write, v.write);
    chk("setup_wdata", P_wdata, v.wdata);
    chk("setup_cmd_ready", cmd_ready, 0);
    // slave noise outside ACCESS must be ignored
    P_ready = 1'b1; P_slverr = 1'b1; P_rdata = 32'hBAD0_BAD0;
    acc = 0;
    do begin
      @(negedge P_clk);
      acc++;
      chk("access_selx_enable", {P_selx, P_enable}, 2'b11);
      chk("access_addr_stable", P_addr, v.addr);
      P_ready  = (acc == v.waits + 1);
      P_slverr = P_ready ? v.slverr : 1'b1;
      P_rdata  = P_ready ? v.rdata : 32'h5555_AAAA;
    end while (!P_ready && acc < 40);
    chk("access_cycles", acc, v.waits + 1);
    @(negedge P_clk);
    P_ready = 1'b0; P_slverr = 1'b0; P_rdata = 32'hFFFF_0000;
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("idle_selx_enable", {P_selx, P_enable}, 2'b00);
    chk("idle_addr_hold", P_addr, v.addr);
    chk("idle_cmd_ready", cmd_ready, 1);
    @(negedge P_clk);
    chk("rsp_pulse_end", rsp_valid, 0);
  endtask

  initial begin
    int acc;
    int c_rsp1, c_setup2, c_rsp2;

    //       write addr          wdata         waits slverr rdata         exp_rdata     exp_err
    vecs[0] = '{1'b1, 32'h04,       32'hDEADBEEF, 0, 1'b0, 32'h1234_5678, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h04,       32'h0,        3, 1'b0, 32'hDEADBEEF,  32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h08,       32'hCAFEF00D, 0, 1'b1, 32'h0,         32'h0,        1'b1};
    vecs[3] = '{1'b0, 32'h10,       32'h0,        1, 1'b1, 32'h0000_A5A5, 32'h0000_A5A5, 1'b1};
    vecs[4] = '{1'b0, 32'hFFFFFFFC, 32'h0,        0, 1'b0, 32'h0,         32'h0,        1'b0};
    vecs[5] = '{1'b1, 32'h20,       32'h0BAD_F00D, 2, 1'b0, 32'h7777_7777, 32'h0,       1'b0};

    // reset state, with a command and slave noise presented during reset
    cmd_valid = 1'b1; cmd_addr = 32'h44; P_ready = 1'b1;
    @(negedge P_clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_selx_enable", {P_selx, P_enable}, 2'b00);
    chk("rst_write", P_write, 0);
    chk("rst_addr", P_addr, 0);
    chk("rst_wdata", P_wdata, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 2'b00);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    cmd_valid = 1'b0; P_ready = 1'b0;
    @(negedge P_clk);
    P_rst = 1'b0;

    // first command in the first cycle after release, then the table
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // back-to-back with cmd_valid held high
    @(negedge P_clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h1111_1111;
    @(negedge P_clk);
    chk("b2b_setup1_addr", P_addr, 32'h30);
    cmd_write = 1'b0; cmd_addr = 32'h34; cmd_wdata = 32'h0;
    @(negedge P_clk);
    chk("b2b_access1", {P_selx, P_enable}, 2'b11);
    P_ready = 1'b1; P_rdata = 32'h2222_2222;
    @(negedge P_clk);
    P_ready = 1'b0;
    chk("b2b_rsp1_valid", rsp_valid, 1);
    chk("b2b_rsp1_rdata", rsp_rdata, 0);
    c_rsp1 = cyc;
    @(negedge P_clk);
    cmd_valid = 1'b0;
    c_setup2 = cyc;
    chk("b2b_setup2_phase", {P_selx, P_enable}, 2'b10);
    chk("b2b_setup2_addr", P_addr, 32'h34);
    chk("b2b_setup2_write", P_write, 0);
    chk("b2b_setup_gap", c_setup2 - c_rsp1, 1);
    @(negedge P_clk);
    P_ready = 1'b1; P_rdata = 32'h3333_4444;
    @(negedge P_clk);
    P_ready = 1'b0;
    c_rsp2 = cyc;
    chk("b2b_rsp2_valid", rsp_valid, 1);
    chk("b2b_rsp2_rdata", rsp_rdata, 32'h3333_4444);
    chk("b2b_period", c_rsp2 - c_rsp1, 3);

    // reset in the middle of ACCESS
    @(negedge P_clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h5050_5050;
    #1;
    @(negedge P_clk);
    cmd_valid = 1'b0;
    @(negedge P_clk);
    chk("rstmid_in_access", {P_selx, P_enable}, 2'b11);
    #2 P_rst = 1'b1;
    #1;
    chk("rstmid_selx_enable", {P_selx, P_enable}, 2'b00);
    chk("rstmid_addr", P_addr, 0);
    chk("rstmid_cmd_ready", cmd_ready, 0);
    P_ready = 1'b1;
    @(negedge P_clk);
    P_ready = 1'b0;
    P_rst = 1'b0;
    chk("rstmid_no_rsp", rsp_valid, 0);
    run_vec(vecs[1]);

`ifdef APB_MASTER_TIMEOUT_EN
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60; P_rdata = 32'h9999_9999;
    #1;
    @(negedge P_clk);
    cmd_valid = 1'b0;
    acc = 0;
    do begin
      @(negedge P_clk);
      if (!rsp_valid && P_enable) acc++;
    end while (!rsp_valid && acc < 40);
    chk("to_access_cycles", acc, 16);
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_err", rsp_err, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_idle", {P_selx, P_enable, cmd_ready}, 3'b001);
    @(negedge P_clk);
`else
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h60;
    #1;
    @(negedge P_clk);
    cmd_valid = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge P_clk);
      if (rsp_valid) acc++;
    end
    chk("nto_no_rsp", acc, 0);
    chk("nto_still_access", {P_selx, P_enable}, 2'b11);
    P_rst = 1'b1;
    @(negedge P_clk);
    P_rst = 1'b0;
`endif
    run_vec(vecs[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
